// File: rtl/p4_router_pkg.sv
// Shared definitions for the P4 router ingress/egress merge stages.
// Arbiter state encoding and port-index width helper.
package p4_router_pkg;

    localparam int MAX_ING_PORTS = 16;

    function automatic int port_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/p4_router_rr_picker.sv
// Combinational rotating-priority encoder: first requester searching upward
// from last_grant+1 (mod N). Shared by the ingress arbiter and egress scheduler.
module p4_router_rr_picker
    import p4_router_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = port_id_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] probe;

    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        probe       = '0;
        for (int k = 1; k <= N; k++) begin
            probe = IDX_W'((int'(last_grant) + k) % N);
            if (!grant_valid && req[probe]) begin
                grant[probe] = 1'b1;
                grant_idx    = probe;
                grant_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/p4_router_ingress_arb.sv
// Packet-atomic round-robin merge of NUM_PORTS AXI-Stream ingress ports, tagging
// each beat with its source port. Optional statistics: P4_ROUTER_INGRESS_ARB_STATS_EN.
module p4_router_ingress_arb
    import p4_router_pkg::*;
#(
    parameter  int NUM_PORTS  = 4,
    parameter  int DATA_BYTES = 8,
    parameter  int TUSER_W    = 1,
    localparam int PORT_ID_W  = port_id_width(NUM_PORTS)
) (
    input  logic                              clk,
    input  logic                              sreset,
    input  logic [NUM_PORTS-1:0]              port_en,
    input  logic [NUM_PORTS-1:0]              s_tvalid,
    output logic [NUM_PORTS-1:0]              s_tready,
    input  logic [NUM_PORTS*DATA_BYTES*8-1:0] s_tdata,
    input  logic [NUM_PORTS*DATA_BYTES-1:0]   s_tkeep,
    input  logic [NUM_PORTS-1:0]              s_tlast,
    input  logic [NUM_PORTS*TUSER_W-1:0]      s_tuser,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [DATA_BYTES*8-1:0]           m_tdata,
    output logic [DATA_BYTES-1:0]             m_tkeep,
    output logic                              m_tlast,
    output logic [TUSER_W-1:0]                m_tuser,
    output logic [PORT_ID_W-1:0]              m_tid,
    input  logic                              stats_clear,
    output logic [NUM_PORTS*32-1:0]           pkt_cnt,
    output logic [NUM_PORTS*32-1:0]           drop_cnt
);

    localparam int DW = DATA_BYTES * 8;

    arb_state_t           state;
    logic [PORT_ID_W-1:0] cur_port;
    logic [PORT_ID_W-1:0] last_grant;
    logic                 drop_q;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] pick_grant;
    logic [PORT_ID_W-1:0] pick_idx;
    logic                 pick_valid;

    logic [NUM_PORTS-1:0] grant;
    logic [PORT_ID_W-1:0] gnt_idx;
    logic                 gnt_valid;
    logic                 load;
    logic                 accept;
    logic                 start_drop;
    logic                 dropping;
    logic                 fwd;

    logic                 sel_valid;
    logic                 sel_last;
    logic                 sel_en;
    logic [DW-1:0]        sel_data;
    logic [DATA_BYTES-1:0] sel_keep;
    logic [TUSER_W-1:0]   sel_user;

`ifdef P4_ROUTER_INGRESS_ARB_STATS_EN
    logic [NUM_PORTS-1:0] discard_mark;

    always_comb begin
        discard_mark = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            discard_mark[p] = s_tuser[p*TUSER_W];
        end
    end

    // A disabled port may still win arbitration when it carries the discard marker, so it gets drained.
    assign req        = s_tvalid & (port_en | discard_mark);
    assign start_drop = !sel_en;
`else
    assign req        = s_tvalid & port_en;
    assign start_drop = 1'b0;
`endif

    p4_router_rr_picker #(
        .N     (NUM_PORTS),
        .IDX_W (PORT_ID_W)
    ) u_picker (
        .req         (req),
        .last_grant  (last_grant),
        .grant       (pick_grant),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    assign load      = !m_tvalid || m_tready;
    assign gnt_valid = (state == ARB_LOCKED) || pick_valid;
    assign gnt_idx   = (state == ARB_LOCKED) ? cur_port : pick_idx;

    always_comb begin
        grant     = pick_grant;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_en    = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        if (state == ARB_LOCKED) begin
            grant           = '0;
            grant[cur_port] = 1'b1;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (PORT_ID_W'(p) == gnt_idx) begin
                sel_valid = s_tvalid[p];
                sel_last  = s_tlast[p];
                sel_en    = port_en[p];
                sel_data  = s_tdata[p*DW +: DW];
                sel_keep  = s_tkeep[p*DATA_BYTES +: DATA_BYTES];
                sel_user  = s_tuser[p*TUSER_W +: TUSER_W];
            end
        end
    end

    assign s_tready = load ? grant : '0;
    assign accept   = load && gnt_valid && sel_valid;
    // A packet is dropped for its whole length once its first beat was taken in drop mode.
    assign dropping = (state == ARB_LOCKED) ? drop_q : start_drop;
    assign fwd      = accept && !dropping;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (sreset) begin
            state      <= ARB_IDLE;
            cur_port   <= '0;
            last_grant <= PORT_ID_W'(NUM_PORTS - 1);
            drop_q     <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tlast    <= 1'b0;
            m_tuser    <= '0;
            m_tid      <= '0;
        end else begin
            if (load) begin
                m_tvalid <= fwd;
                if (fwd) begin
                    m_tdata <= sel_data;
                    m_tkeep <= sel_keep;
                    m_tlast <= sel_last;
                    m_tuser <= sel_user;
                    m_tid   <= gnt_idx;
                end
            end
            if (accept) begin
                if (sel_last) begin
                    state      <= ARB_IDLE;
                    last_grant <= gnt_idx;
                    drop_q     <= 1'b0;
                end else if (state == ARB_IDLE) begin
                    state    <= ARB_LOCKED;
                    cur_port <= gnt_idx;
                    drop_q   <= start_drop;
                end
            end
        end
    end

`ifdef P4_ROUTER_INGRESS_ARB_STATS_EN
    logic [NUM_PORTS-1:0] pkt_inc;
    logic [NUM_PORTS-1:0] drop_inc;

    // pkt_cnt counts forwarded packets only; discarded packets are tallied in drop_cnt.
    assign pkt_inc  = (accept && sel_last && !dropping) ? grant : '0;
    assign drop_inc = (accept && (state == ARB_IDLE) && start_drop) ? grant : '0;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stats
        logic [31:0] pkt_r;
        logic [31:0] drop_r;

        always_ff @(posedge clk) begin
            // NOTE: counters are plain registers with an explicit reset; stats_clear wins over a same-cycle increment.
            if (sreset || stats_clear) begin
                pkt_r  <= '0;
                drop_r <= '0;
            end else begin
                if (pkt_inc[p] && (pkt_r != '1)) begin
                    pkt_r <= pkt_r + 32'd1;
                end
                if (drop_inc[p] && (drop_r != '1)) begin
                    drop_r <= drop_r + 32'd1;
                end
            end
        end

        assign pkt_cnt[p*32 +: 32]  = pkt_r;
        assign drop_cnt[p*32 +: 32] = drop_r;
    end
`else
    logic unused_stats_clear;

    assign unused_stats_clear = stats_clear;
    assign pkt_cnt            = '0;
    assign drop_cnt           = '0;
`endif

endmodule

// File: tb/tb_p4_router_ingress_arb.sv
// Self-checking bench for p4_router_ingress_arb: directed scenarios plus randomized
// traffic against a packet-queue reference model (stats checks follow P4_ROUTER_INGRESS_ARB_STATS_EN).
module tb_p4_router_ingress_arb;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int DW = DB * 8;
    localparam int TU = 1;
`ifdef P4_ROUTER_INGRESS_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              sreset;
    logic [N-1:0]      port_en;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata;
    logic [N*DB-1:0]   s_tkeep;
    logic [N-1:0]      s_tlast;
    logic [N*TU-1:0]   s_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [DB-1:0]     m_tkeep;
    logic              m_tlast;
    logic [TU-1:0]     m_tuser;
    logic [1:0]        m_tid;
    logic              stats_clear;
    logic [N*32-1:0]   pkt_cnt;
    logic [N*32-1:0]   drop_cnt;

    always #5 clk = ~clk;

    p4_router_ingress_arb #(
        .NUM_PORTS  (N),
        .DATA_BYTES (DB),
        .TUSER_W    (TU)
    ) dut (
        .clk         (clk),
        .sreset      (sreset),
        .port_en     (port_en),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .m_tid       (m_tid),
        .stats_clear (stats_clear),
        .pkt_cnt     (pkt_cnt),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [DB-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    // Upstream packet sources: beats waiting per port, valid hold and mid-packet flags.
    beat_t txq [N][$];
    bit    vhold [N];
    bit    mid   [N];
    int    vprob    = 100;
    int    rdy_mode = 0;
    int    cyc      = 0;

    // Reference model: arbitration state, output register contents, statistics.
    bit          md_locked = 1'b0;
    bit          md_drop   = 1'b0;
    int          md_cur    = 0;
    int          md_last   = N - 1;
    bit          mv        = 1'b0;
    beat_t       mbeat;
    int          mtid      = 0;
    int unsigned pkt_m  [N];
    int unsigned drop_m [N];

    int out_tids[$];
    int out_cyc[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int p, input int len, input logic user);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = 8'($urandom);
            b.last = (i == len - 1);
            b.user = user;
            txq[p].push_back(b);
        end
    endtask

    function automatic bit busy();
        for (int p = 0; p < N; p++) begin
            if (txq[p].size() != 0) return 1'b1;
        end
        return mv;
    endfunction

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (!sreset && txq[p].size() != 0 && (vhold[p] || $urandom_range(99) < vprob)) begin
                vhold[p]              = 1'b1;
                s_tvalid[p]           = 1'b1;
                s_tdata[p*DW +: DW]   = txq[p][0].data;
                s_tkeep[p*DB +: DB]   = txq[p][0].keep;
                s_tlast[p]            = txq[p][0].last;
                s_tuser[p]            = txq[p][0].user;
            end else begin
                s_tvalid[p]           = 1'b0;
                s_tdata[p*DW +: DW]   = {$urandom, $urandom};
                s_tkeep[p*DB +: DB]   = 8'($urandom);
                s_tlast[p]            = 1'($urandom);
                s_tuser[p]            = 1'($urandom);
            end
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(99) < 65);
        endcase
    endtask

    // Runs at the falling edge: compares DUT against the model, then advances the model across the next rising edge.
    task automatic eval();
        bit           load;
        bit           gv;
        bit           acc;
        bit           drp;
        int           g;
        logic [N-1:0] exp_rdy;

        check("m_tvalid", m_tvalid, mv);
        if (mv) begin
            check("m_tdata", m_tdata, mbeat.data);
            check("m_tkeep", m_tkeep, mbeat.keep);
            check("m_tlast", m_tlast, mbeat.last);
            check("m_tuser", m_tuser, mbeat.user);
            check("m_tid",   m_tid,   mtid);
        end
        for (int p = 0; p < N; p++) begin
            check("pkt_cnt",  pkt_cnt[p*32 +: 32],  pkt_m[p]);
            check("drop_cnt", drop_cnt[p*32 +: 32], drop_m[p]);
        end

        load = !mv || m_tready;
        gv   = 1'b0;
        g    = 0;
        if (md_locked) begin
            gv = 1'b1;
            g  = md_cur;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (md_last + k) % N;
                if (!gv && s_tvalid[p] && (port_en[p] || (STATS && s_tuser[p]))) begin
                    gv = 1'b1;
                    g  = p;
                end
            end
        end
        exp_rdy = '0;
        if (gv && load) exp_rdy[g] = 1'b1;
        check("s_tready", s_tready, exp_rdy);

        if (!sreset && m_tvalid === 1'b1 && m_tready) begin
            out_tids.push_back(int'(m_tid));
            out_cyc.push_back(cyc);
        end

        if (sreset) begin
            md_locked = 1'b0;
            md_drop   = 1'b0;
            md_last   = N - 1;
            mv        = 1'b0;
            for (int p = 0; p < N; p++) begin
                pkt_m[p]  = 0;
                drop_m[p] = 0;
                vhold[p]  = 1'b0;
                if (mid[p]) begin
                    while (txq[p].size() != 0 && !txq[p][0].last) void'(txq[p].pop_front());
                    if (txq[p].size() != 0) void'(txq[p].pop_front());
                    mid[p] = 1'b0;
                end
            end
        end else begin
            acc = gv && load && s_tvalid[g];
            drp = md_locked ? md_drop : (STATS && !port_en[g]);
            if (stats_clear && STATS) begin
                for (int p = 0; p < N; p++) begin
                    pkt_m[p]  = 0;
                    drop_m[p] = 0;
                end
            end else if (acc && STATS) begin
                if (txq[g][0].last && !drp && pkt_m[g] != 32'hFFFF_FFFF) pkt_m[g]++;
                if (!md_locked && drp && drop_m[g] != 32'hFFFF_FFFF) drop_m[g]++;
            end
            if (load) mv = acc && !drp;
            if (acc) begin
                if (!drp) begin
                    mbeat = txq[g][0];
                    mtid  = g;
                end
                if (txq[g][0].last) begin
                    md_locked = 1'b0;
                    md_drop   = 1'b0;
                    md_last   = g;
                    mid[g]    = 1'b0;
                end else begin
                    if (!md_locked) md_drop = drp;
                    md_locked = 1'b1;
                    md_cur    = g;
                    mid[g]    = 1'b1;
                end
                void'(txq[g].pop_front());
                vhold[g] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input string tag, input int max);
        int n;
        n = 0;
        while (busy() && n < max) begin
            cycle();
            n++;
        end
        check(tag, busy(), 1'b0);
    endtask

    task automatic run_until_left(input string tag, input int p, input int left, input int max);
        int n;
        n = 0;
        while (txq[p].size() > left && n < max) begin
            cycle();
            n++;
        end
        check(tag, txq[p].size() > left, 1'b0);
    endtask

    initial begin
        int n2;

        sreset      = 1'b1;
        port_en     = '1;
        s_tvalid    = '0;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tlast     = '0;
        s_tuser     = '0;
        m_tready    = 1'b1;
        stats_clear = 1'b0;
        for (int p = 0; p < N; p++) begin
            pkt_m[p]  = 0;
            drop_m[p] = 0;
        end
        @(posedge clk);
        #1;
        run(2);
        sreset = 1'b0;
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata",  m_tdata, '0);
        check("rst_m_tid",    m_tid, '0);
        check("rst_s_tready", s_tready, '0);

        // Two 3-beat packets: back-to-back, port 0 first.
        out_tids.delete();
        out_cyc.delete();
        add_pkt(0, 3, 1'b0);
        add_pkt(2, 3, 1'b0);
        drain("t1_drain", 50);
        check("t1_count", out_tids.size(), 6);
        if (out_tids.size() == 6) begin
            for (int i = 0; i < 6; i++) check("t1_tid", out_tids[i], (i < 3) ? 0 : 2);
            check("t1_span", out_cyc[5] - out_cyc[0], 5);
        end

        // 4-beat packet on port 1, port 3 joins during beat 2, m_tready toggling.
        out_tids.delete();
        rdy_mode = 1;
        add_pkt(1, 4, 1'b0);
        run_until_left("t2_start", 1, 3, 20);
        add_pkt(3, 2, 1'b0);
        drain("t2_drain", 80);
        check("t2_count", out_tids.size(), 6);
        if (out_tids.size() == 6) begin
            for (int i = 0; i < 6; i++) check("t2_tid", out_tids[i], (i < 4) ? 1 : 3);
        end
        rdy_mode = 0;

        // Single-beat packets on all ports: strict rotation at full rate.
        out_tids.delete();
        out_cyc.delete();
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < N; p++) add_pkt(p, 1, 1'b0);
        end
        drain("t3_drain", 60);
        check("t3_count", out_tids.size(), 12);
        if (out_tids.size() == 12) begin
            for (int i = 0; i < 12; i++) check("t3_tid", out_tids[i], i % N);
            check("t3_span", out_cyc[11] - out_cyc[0], 11);
        end

        // Port 0 disabled mid-packet: packet completes, then no more port 0 grants.
        out_tids.delete();
        add_pkt(0, 5, 1'b0);
        add_pkt(0, 2, 1'b0);
        add_pkt(1, 2, 1'b0);
        run_until_left("t4_beat2", 0, 5, 20);
        port_en[0] = 1'b0;
        run(25);
        check("t4_count", out_tids.size(), 7);
        if (out_tids.size() == 7) begin
            for (int i = 0; i < 7; i++) check("t4_tid", out_tids[i], (i < 5) ? 0 : 1);
        end
        port_en[0] = 1'b1;
        drain("t4_drain", 50);

        // Reset on beat 2 of 4: partial packet abandoned, port 0 regains priority.
        add_pkt(0, 4, 1'b0);
        run_until_left("t5_beat2", 0, 2, 20);
        sreset = 1'b1;
        cycle();
        sreset = 1'b0;
        check("t5_m_tvalid", m_tvalid, 1'b0);
        check("t5_s_tready", s_tready, '0);
        out_tids.delete();
        add_pkt(3, 1, 1'b0);
        add_pkt(0, 1, 1'b0);
        drain("t5_drain", 30);
        check("t5_count", out_tids.size(), 2);
        if (out_tids.size() == 2) begin
            check("t5_first", out_tids[0], 0);
            check("t5_second", out_tids[1], 3);
        end

`ifdef P4_ROUTER_INGRESS_ARB_STATS_EN
        // Packet counting, discard of a marked packet on a disabled port, clear.
        out_tids.delete();
        for (int i = 0; i < 3; i++) add_pkt(1, 2, 1'b0);
        drain("t6_drain1", 50);
        port_en[2] = 1'b0;
        add_pkt(2, 3, 1'b1);
        drain("t6_drain2", 50);
        check("t6_pkt1", pkt_cnt[1*32 +: 32], 3);
        check("t6_drop2", drop_cnt[2*32 +: 32], 1);
        n2 = 0;
        foreach (out_tids[i]) if (out_tids[i] == 2) n2++;
        check("t6_no_port2", n2, 0);
        stats_clear = 1'b1;
        cycle();
        stats_clear = 1'b0;
        check("t6_clear_pkt", pkt_cnt, '0);
        check("t6_clear_drop", drop_cnt, '0);
        port_en[2] = 1'b1;
`else
        n2 = 0;
        check("t6_pkt_tied", pkt_cnt, '0);
        check("t6_drop_tied", drop_cnt, '0);
`endif

        // Randomized traffic with port_en changes and back-pressure.
        vprob    = 70;
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 15) begin
                int p;
                p = $urandom_range(N - 1);
                if (txq[p].size() < 8) add_pkt(p, $urandom_range(1, 5), 1'($urandom));
            end
            if ($urandom_range(99) < 3) port_en[$urandom_range(N - 1)] ^= 1'b1;
            stats_clear = ($urandom_range(99) < 2);
            cycle();
        end
        stats_clear = 1'b0;
        port_en     = '1;
        drain("rand_drain", 600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
